// File: rtl/alu_pkg.sv
// Shared widths, packer state encoding and the zero-padding mask helper
// for the ALU result concatenation blocks.
package alu_pkg;

   localparam int ALU_NIB_W      = 4;
   localparam int ALU_PACK_LANES = 2;
   // Upper bound on a packed word; lane_mask results are cast down to OUT_W.
   localparam int ALU_MAX_W      = 1024;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } pack_state_e;

   // Ones over the top lanes_kept lanes of an out_w-bit word (lane 0 = MSBs).
   function automatic logic [ALU_MAX_W-1:0] lane_mask(input int lanes_kept,
                                                      input int in_w,
                                                      input int out_w);
      logic [ALU_MAX_W-1:0] m;
      m = '0;
      for (int b = 0; b < ALU_MAX_W; b++) begin
         if ((b < out_w) && (b >= out_w - lanes_kept * in_w)) begin
            m[b] = 1'b1;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/alu_lane_insert.sv
// Writes one beat into a lane of the packed word, clearing all lanes below it.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module alu_lane_insert
   import alu_pkg::*;
#(
   parameter int IN_W  = ALU_NIB_W,
   parameter int LANES = ALU_PACK_LANES,
   localparam int CNT_W = $clog2(LANES + 1),
   localparam int OUT_W = IN_W * LANES
) (
   input  logic [OUT_W-1:0] word_in,
   input  logic [IN_W-1:0]  beat,
   input  logic [CNT_W-1:0] lane,
   output logic [OUT_W-1:0] word_out
);

   // Lane j occupies bits [IN_W*(LANES-j)-1 -: IN_W]; higher j means lower bits.
   always_comb begin
      word_out = word_in;
      for (int j = 0; j < LANES; j++) begin
         if (j == int'(lane)) begin
            word_out[IN_W*(LANES-j)-1 -: IN_W] = beat;
         end else if (j > int'(lane)) begin
            word_out[IN_W*(LANES-j)-1 -: IN_W] = '0;
         end
      end
   end

endmodule

// File: rtl/alu_conc_packer.sv
// Packs LANES narrow beats (first beat in MSBs) into one registered wide word.
// Latency: 1 cycle from closing beat to out_valid; one beat per cycle sustained.
// Backpressure: in_ready follows out_ready while a word is held (same-cycle bypass).
module alu_conc_packer
   import alu_pkg::*;
#(
   parameter int IN_W  = ALU_NIB_W,
   parameter int LANES = ALU_PACK_LANES,
   localparam int CNT_W = $clog2(LANES + 1),
   localparam int OUT_W = IN_W * LANES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [CNT_W-1:0] out_lanes,
   output logic             out_valid,
   input  logic             out_ready
);

   pack_state_e      state;
   logic [CNT_W-1:0] count;
   logic [OUT_W-1:0] asm_q;
   logic [OUT_W-1:0] ins_word;
   logic [OUT_W-1:0] pad_mask;
   logic             beat_fire;
   logic             word_fire;
   logic             close;

   assign out_valid = (state == HOLD);
   assign in_ready  = !rst && ((state == FILL) || out_ready);
   assign beat_fire = in_valid && in_ready;
   assign word_fire = out_valid && out_ready;
   assign close     = beat_fire && (in_last || (count == CNT_W'(LANES - 1)));
   assign pad_mask  = OUT_W'(lane_mask(int'(count) + 1, IN_W, OUT_W));

   // count is 0 throughout HOLD, so a bypassed beat always lands in lane 0.
   alu_lane_insert #(
      .IN_W  (IN_W),
      .LANES (LANES)
   ) u_lane_insert (
      .word_in  (asm_q),
      .beat     (in_data),
      .lane     (count),
      .word_out (ins_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FILL;
         count     <= '0;
         asm_q     <= '0;
         out_data  <= '0;
         out_lanes <= '0;
      end else if (beat_fire) begin
         asm_q <= ins_word;
         if (close) begin
            out_data  <= ins_word & pad_mask;
            out_lanes <= count + 1'b1;
            count     <= '0;
            state     <= HOLD;
         end else begin
            // A non-closing beat in HOLD implies the held word just transferred.
            count <= count + 1'b1;
            state <= FILL;
         end
      end else if (word_fire) begin
         state <= FILL;
      end
   end

endmodule

// File: tb/tb_alu_conc_packer.sv
// Bench for alu_conc_packer: cycle vector table, reset and wide-config
// sequences, then random traffic against a beat-queue reference model.
module tb_alu_conc_packer;

   localparam int IW  = 4;
   localparam int LN  = 2;
   localparam int CW  = 2;
   localparam int OW  = 8;
   localparam int IWB = 8;
   localparam int LNB = 4;
   localparam int CWB = 3;
   localparam int OWB = 32;

   logic          clk;
   logic          rst;
   logic [IW-1:0] in_data;
   logic          in_valid;
   logic          in_last;
   logic          in_ready;
   logic [OW-1:0] out_data;
   logic [CW-1:0] out_lanes;
   logic          out_valid;
   logic          out_ready;

   logic [IWB-1:0] in_data_b;
   logic           in_valid_b;
   logic           in_last_b;
   logic           in_ready_b;
   logic [OWB-1:0] out_data_b;
   logic [CWB-1:0] out_lanes_b;
   logic           out_valid_b;
   logic           out_ready_b;

   int n_checks = 0;
   int n_fail   = 0;

   alu_conc_packer #(.IN_W(IW), .LANES(LN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_lanes (out_lanes),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   alu_conc_packer #(.IN_W(IWB), .LANES(LNB)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data_b),
      .in_valid  (in_valid_b),
      .in_last   (in_last_b),
      .in_ready  (in_ready_b),
      .out_data  (out_data_b),
      .out_lanes (out_lanes_b),
      .out_valid (out_valid_b),
      .out_ready (out_ready_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          iv;
      logic [IW-1:0] d;
      logic          l;
      logic          r;
      logic          e_irdy;
      logic          e_ov;
      logic [OW-1:0] e_od;
      logic [CW-1:0] e_ol;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic iv, input logic [IW-1:0] d, input logic l,
                               input logic r, input logic e_irdy, input logic e_ov,
                               input logic [OW-1:0] e_od, input logic [CW-1:0] e_ol);
      vec_t v;
      v.iv = iv; v.d = d; v.l = l; v.r = r;
      v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_od = e_od; v.e_ol = e_ol;
      return v;
   endfunction

   // Called at posedge+1; ends at the following posedge+1.
   task automatic apply(input vec_t v, input string tag);
      in_valid  = v.iv;
      in_data   = v.d;
      in_last   = v.l;
      out_ready = v.r;
      #1;
      check({tag, " in_ready"}, 64'(in_ready), 64'(v.e_irdy));
      @(posedge clk);
      #1;
      check({tag, " out_valid"}, 64'(out_valid), 64'(v.e_ov));
      if (v.e_ov) begin
         check({tag, " out_data"}, 64'(out_data), 64'(v.e_od));
         check({tag, " out_lanes"}, 64'(out_lanes), 64'(v.e_ol));
      end
   endtask

   task automatic step_b();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic          mv;
      logic [OW-1:0] md;
      int            ml;
      int            part[$];
      logic          exp_rdy;

      rst = 1'b0;
      in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      in_data_b = '0; in_valid_b = 1'b0; in_last_b = 1'b0; out_ready_b = 1'b0;
      #2 rst = 1'b1;
      out_ready = 1'b1;
      #1;
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset out_data", 64'(out_data), 64'd0);
      check("reset out_lanes", 64'(out_lanes), 64'd0);
      check("reset in_ready", 64'(in_ready), 64'd0);
      check("reset b out_valid", 64'(out_valid_b), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Full word, short word then clean lower lane, backpressure, bypass.
      tbl.push_back(mk(1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0));
      tbl.push_back(mk(1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 2'd2));
      tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0));
      tbl.push_back(mk(1'b1, 4'h3, 1'b1, 1'b1, 1'b1, 1'b1, 8'h30, 2'd1));
      tbl.push_back(mk(1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0));
      tbl.push_back(mk(1'b1, 4'hD, 1'b0, 1'b1, 1'b1, 1'b1, 8'hCD, 2'd2));
      tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0));
      tbl.push_back(mk(1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0));
      tbl.push_back(mk(1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 2'd2));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 2'd2));
      tbl.push_back(mk(1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0));
      tbl.push_back(mk(1'b1, 4'h8, 1'b0, 1'b1, 1'b1, 1'b1, 8'h78, 2'd2));
      tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0));
      // Back-to-back beats 1..8 with no stall.
      for (int i = 1; i <= 8; i++)
         tbl.push_back(mk(1'b1, 4'(i), 1'b0, 1'b1, 1'b1, (i % 2) == 0,
                          8'({4'(i - 1), 4'(i)}), 2'd2));
      tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0));
      // in_last on the final lane, then a one-beat word closed in the bypass.
      tbl.push_back(mk(1'b1, 4'hE, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0));
      tbl.push_back(mk(1'b1, 4'hB, 1'b1, 1'b1, 1'b1, 1'b1, 8'hEB, 2'd2));
      tbl.push_back(mk(1'b1, 4'h6, 1'b1, 1'b1, 1'b1, 1'b1, 8'h60, 2'd1));
      tbl.push_back(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0));
      foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

      // Reset with a partial word, then with a held word.
      apply(mk(1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0), "rstA beat");
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("rstA out_valid", 64'(out_valid), 64'd0);
      check("rstA out_data", 64'(out_data), 64'd0);
      check("rstA in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      apply(mk(1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0), "rstB beat0");
      apply(mk(1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 1'b1, 8'h34, 2'd2), "rstB beat1");
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rstB out_valid", 64'(out_valid), 64'd0);
      check("rstB out_data", 64'(out_data), 64'd0);
      check("rstB out_lanes", 64'(out_lanes), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      apply(mk(1'b1, 4'h9, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0), "post-rst beat0");
      apply(mk(1'b1, 4'h6, 1'b0, 1'b1, 1'b1, 1'b1, 8'h96, 2'd2), "post-rst beat1");
      apply(mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0), "post-rst drain");

      // Wide configuration: early close on lane 2, then a full word via bypass.
      in_valid_b = 1'b1; out_ready_b = 1'b0;
      in_data_b = 8'hDE; step_b();
      in_data_b = 8'hAD; step_b();
      in_data_b = 8'hBE; in_last_b = 1'b1; step_b();
      check("wide out_valid", 64'(out_valid_b), 64'd1);
      check("wide out_data", 64'(out_data_b), 64'hDEADBE00);
      check("wide out_lanes", 64'(out_lanes_b), 64'd3);
      in_last_b = 1'b0; in_data_b = 8'h11;
      #1;
      check("wide in_ready held", 64'(in_ready_b), 64'd0);
      out_ready_b = 1'b1;
      step_b();
      check("wide bypass out_valid", 64'(out_valid_b), 64'd0);
      in_data_b = 8'h22; step_b();
      in_data_b = 8'h33; step_b();
      in_data_b = 8'h44; step_b();
      check("wide full out_data", 64'(out_data_b), 64'h11223344);
      check("wide full out_lanes", 64'(out_lanes_b), 64'd4);
      in_valid_b = 1'b0; step_b();

      // Random traffic against a queue-of-beats model.
      rst = 1'b1;
      #2 rst = 1'b0;
      mv = 1'b0; md = '0; ml = 0;
      part.delete();
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 4'($urandom);
         in_last   = ($urandom_range(0, 4) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         exp_rdy   = !mv || out_ready;
         #1;
         check($sformatf("rnd%0d in_ready", c), 64'(in_ready), 64'(exp_rdy));
         @(posedge clk);
         if (mv && out_ready) mv = 1'b0;
         if (in_valid && exp_rdy) begin
            part.push_back(int'(in_data));
            if (part.size() == LN || in_last) begin
               md = '0;
               foreach (part[i]) md = md | (OW'(part[i]) << (IW * (LN - 1 - i)));
               ml = part.size();
               mv = 1'b1;
               part.delete();
            end
         end
         #1;
         check($sformatf("rnd%0d out_valid", c), 64'(out_valid), 64'(mv));
         if (mv) begin
            check($sformatf("rnd%0d out_data", c), 64'(out_data), 64'(md));
            check($sformatf("rnd%0d out_lanes", c), 64'(out_lanes), 64'(ml));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_conc_packer.md
Name: alu_conc_packer

Overview:
Parametrised, registered successor to the team's fixed 4+4-bit operand concatenator. Accepts a stream of IN_W-bit beats over a valid/ready handshake and packs LANES beats into one OUT_W = IN_W*LANES word. The first beat goes in the MSBs, matching the existing {A, B} ordering. Supports early word close (in_last) with zero padding and output backpressure; sits between narrow ALU result producers and wide consumers.

Parameters:
IN_W, 4, width of one input beat (>=1)
LANES, 2, beats per output word (>=2)
CNT_W, $clog2(LANES+1), width of lane count fields (derived localparam, not overridable)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_data  input  IN_W  input beat
in_valid  input  1  in_data valid
in_last  input  1  qualifies beat as final of word; closes word early
in_ready  output  1  block accepts beat this cycle
out_data  output  IN_W*LANES  packed word, beat 0 in MSBs
out_lanes  output  CNT_W  number of valid beats in out_data (1..LANES)
out_valid  output  1  out_data/out_lanes valid
out_ready  input  1  downstream accepts word

Interface fixed: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (async assert, sync release to clk): out_valid=0, out_data=0, out_lanes=0, internal count=0, state=FILL. in_ready is 0 while rst is high.
- Beat transfer occurs on a cycle where in_valid && in_ready. Word transfer occurs on a cycle where out_valid && out_ready.
- State FILL (out_valid=0): in_ready=1.
  - Each accepted beat k (k=count, 0-based) is written to bits [IN_W*(LANES-k)-1 : IN_W*(LANES-k-1)] of the assembly register; count increments.
  - Close condition: accepted beat has count==LANES-1, or in_last=1. On close:
    - Next cycle out_valid=1.
    - out_data = assembled word with unfilled lower lanes forced to 0.
    - out_lanes = k+1.
    - count goes to 0; state goes to HOLD.
- State HOLD (out_valid=1):
  - out_data and out_lanes are held stable until a word transfer occurs.
  - in_ready = out_ready (same-cycle bypass).
  - Word transfer with no beat: out_valid->0, state->FILL.
  - Word transfer with a simultaneous beat: the beat becomes lane 0 of a new word (count=1); the assembly register's other lanes are cleared.
  - If that beat also closes the word (in_last=1), HOLD is kept: the next cycle presents the new word (out_lanes=1).
- Latency: 1 cycle from the closing beat to out_valid. Sustained throughput is one beat per cycle, with no bubble between words.
- in_last with no beats pending is impossible, because the beat carrying in_last is itself counted; out_lanes is never 0 while out_valid=1.
- in_last on lane LANES-1 is identical to a normal full close.
- in_valid=0 while in FILL with partial count: the partial word is held indefinitely; there is no timeout.
- in_data and in_last are ignored when no transfer occurs.
- out_data is a pure register output; there is no combinational path from in_data to out_data. in_ready depends combinationally on out_ready only.
- Reset mid-word or mid-HOLD discards all pending data immediately (out_valid drops asynchronously).

Decomposition:
- Shared package alu_pkg holds:
  - default widths ALU_NIB_W=4 and ALU_PACK_LANES=2;
  - a state enum {FILL, HOLD};
  - a helper function lane_mask(count) returning the zero-padding mask.
- One natural sub-module, alu_lane_insert (combinational): writes an IN_W beat into a lane index of the OUT_W word and clears the lanes below it. It is reused by both the FILL and bypass paths.

Test Plan:
- IN_W=4, LANES=2: beats 0xA then 0x5, out_ready=1 -> out_data=0xA5, out_lanes=2, out_valid exactly 1 cycle after the 0x5 beat.
- Single beat 0x3 with in_last=1 -> out_data=0x30, out_lanes=1; the next word 0xC,0xD gives 0xCD (no stale lower lane).
- Backpressure: word 0x12 formed, out_ready=0 for 5 cycles -> out_data stays 0x12 and in_ready=0. Then out_ready=1 together with beat 0x7 -> 0x12 transfers and 0x7 is held as lane 0; beat 0x8 then gives 0x78.
- Back-to-back: 8 beats 0x1..0x8 with in_valid and out_ready held high -> words 0x12, 0x34, 0x56, 0x78 on consecutive odd cycles, no stall.
- Reset mid-operation: after beat 0xF (count=1), assert rst -> out_valid=0 and out_data=0 immediately. After release, beats 0x9,0x6 give 0x96, out_lanes=2.
- LANES=4, IN_W=8: beats 0xDE,0xAD,0xBE with last on 0xBE -> out_data=0xDEADBE00, out_lanes=3.
